// File: rtl/nnacc_pkg.sv
// rtl/nnacc_pkg.sv - shared state encoding and default frame geometry for the NN accelerator
package nnacc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } frame_state_e;

  localparam int DEF_IMG_W   = 14;
  localparam int DEF_IMG_H   = 14;
  localparam int DEF_CHUNK_W = 7;

endpackage

// File: rtl/chunk_popcount.sv
// rtl/chunk_popcount.sv - combinational count of set bits in one input beat
module chunk_popcount #(
  parameter  int W  = 7,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  bits,
  output logic [CW-1:0] ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < W; i++) begin
      ones = ones + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/image_frame_loader.sv
// rtl/image_frame_loader.sv - assembles a binary frame from pixel beats and holds it with a popcount checksum
module image_frame_loader
  import nnacc_pkg::*;
#(
  parameter  int IMG_W   = DEF_IMG_W,
  parameter  int IMG_H   = DEF_IMG_H,
  parameter  int CHUNK_W = DEF_CHUNK_W,
  localparam int NPIX    = IMG_W * IMG_H,
  localparam int BEATS   = NPIX / CHUNK_W,
  localparam int BW      = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int SW      = $clog2(NPIX + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               in_valid,
  input  logic [CHUNK_W-1:0] in_data,
  output logic               in_ready,
  output logic               img_valid,
  input  logic               img_ack,
  output logic [NPIX-1:0]    img_data,
  output logic [SW-1:0]      pixel_count,
  output logic [BW-1:0]      beat_idx,
  output logic               err_overrun
);

  localparam int CW = $clog2(CHUNK_W + 1);
  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

  generate
    if ((IMG_W * IMG_H) % CHUNK_W != 0) begin : g_bad_chunk
      $error("image_frame_loader: IMG_W*IMG_H must be a multiple of CHUNK_W");
    end
  endgenerate

  frame_state_e  state, state_nxt;
  logic          beat;
  logic          last_beat;
  logic [CW-1:0] chunk_ones;

  chunk_popcount #(.W(CHUNK_W)) u_popcount (
    .bits (in_data),
    .ones (chunk_ones)
  );

  assign beat      = in_valid & in_ready;
  assign last_beat = beat & (beat_idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_LOAD;
      ST_LOAD: if (last_beat) state_nxt = ST_FULL;
      ST_FULL: if (img_ack) state_nxt = ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
    // Restart wins over both a same-cycle beat and a same-cycle ack.
    if (frame_start) state_nxt = ST_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready    <= 1'b0;
      img_valid   <= 1'b0;
      img_data    <= '0;
      pixel_count <= '0;
      beat_idx    <= '0;
      err_overrun <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == ST_LOAD);
      img_valid <= (state_nxt == ST_FULL);
      if (frame_start) begin
        img_data    <= '0;
        pixel_count <= '0;
        beat_idx    <= '0;
        err_overrun <= 1'b0;
      end else begin
        if (beat) begin
          img_data[int'(beat_idx) * CHUNK_W +: CHUNK_W] <= in_data;
          pixel_count <= pixel_count + SW'(chunk_ones);
          beat_idx    <= last_beat ? '0 : beat_idx + 1'b1;
        end
        if (state == ST_FULL) begin
          if (in_valid && !img_ack) err_overrun <= 1'b1;
          if (img_ack) pixel_count <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_image_frame_loader.sv
// tb/tb_image_frame_loader.sv - self-checking bench for image_frame_loader
module tb_image_frame_loader;

  localparam int NPIX  = 196;
  localparam int BEATS = 28;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_start, in_valid, img_ack;
  logic [6:0]   in_data;
  logic         in_ready, img_valid, err_overrun;
  logic [195:0] img_data;
  logic [7:0]   pixel_count;
  logic [4:0]   beat_idx;

  logic         fs2, v2, ack2;
  logic [7:0]   d2;
  logic         rdy2, val2, err2;
  logic [63:0]  img2;
  logic [6:0]   cnt2;
  logic [2:0]   idx2;

  int checks = 0;
  int failures = 0;

  image_frame_loader dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .img_valid(img_valid), .img_ack(img_ack),
    .img_data(img_data), .pixel_count(pixel_count), .beat_idx(beat_idx),
    .err_overrun(err_overrun)
  );

  image_frame_loader #(.IMG_W(8), .IMG_H(8), .CHUNK_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs2), .in_valid(v2),
    .in_data(d2), .in_ready(rdy2), .img_valid(val2), .img_ack(ack2),
    .img_data(img2), .pixel_count(cnt2), .beat_idx(idx2),
    .err_overrun(err2)
  );

  always #5 clk = ~clk;

  // Reference model: the current frame is the list of beats accepted so far.
  bit       m_started, m_held, m_err;
  bit [6:0] m_q[$];
  bit [6:0] m_img[BEATS];

  task automatic model_reset();
    m_started = 0; m_held = 0; m_err = 0;
    m_q.delete();
    for (int i = 0; i < BEATS; i++) m_img[i] = '0;
  endtask

  task automatic model_edge(input bit fs, input bit v, input bit [6:0] d, input bit ack);
    if (fs) begin
      model_reset();
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_held) begin
      if (v && !ack) m_err = 1;
      if (ack) begin
        m_held = 0;
        m_q.delete();
      end
    end else if (v) begin
      m_img[m_q.size()] = d;
      m_q.push_back(d);
      if (m_q.size() == BEATS) m_held = 1;
    end
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [195:0] e_img;
    int           e_cnt;
    e_cnt = 0;
    foreach (m_q[i]) e_cnt += $countones(m_q[i]);
    for (int i = 0; i < BEATS; i++) e_img[i*7 +: 7] = m_img[i];
    check({tag, ".in_ready"},    256'(in_ready),    256'(m_started && !m_held));
    check({tag, ".img_valid"},   256'(img_valid),   256'(m_held));
    check({tag, ".beat_idx"},    256'(beat_idx),    256'(m_held ? 0 : m_q.size()));
    check({tag, ".pixel_count"}, 256'(pixel_count), 256'(e_cnt));
    check({tag, ".err_overrun"}, 256'(err_overrun), 256'(m_err));
    check({tag, ".img_data"},    256'(img_data),    256'(e_img));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(frame_start, in_valid, in_data, img_ack);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    frame_start = 0; in_valid = 0; img_ack = 0; in_data = '0;
  endtask

  logic [195:0] alt_img;
  int           accepted, cyc;

  initial begin
    for (int p = 0; p < NPIX; p++) alt_img[p] = ((p % 7) % 2 == 0);
    idle_inputs();
    fs2 = 0; v2 = 0; ack2 = 0; d2 = '0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.dut8_ready", 256'(rdy2), 256'(0));

    rst_n = 1;
    step("idle_to_load");

    // Reset in the middle of a frame discards the partial frame.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_data = 7'($urandom);
      step("partial");
    end
    idle_inputs();
    rst_n = 0;
    #1;
    model_reset();
    check_all("midreset");
    repeat (3) @(posedge clk);
    #1;
    check_all("midreset_hold");
    rst_n = 1;
    step("after_reset");
    check("after_reset.in_ready", 256'(in_ready), 256'(1));

    // Nominal contiguous frame.
    for (int i = 0; i < BEATS; i++) begin
      in_valid = 1; in_data = 7'b1010101;
      step("nominal");
    end
    idle_inputs();
    check("nominal.count112", 256'(pixel_count), 256'(112));
    check("nominal.pattern", 256'(img_data), 256'(alt_img));
    step("nominal_hold");

    // Offer a beat while the frame is held.
    in_valid = 1; in_data = 7'($urandom);
    step("overrun");
    check("overrun.img_kept", 256'(img_data), 256'(alt_img));
    idle_inputs();
    img_ack = 1;
    step("ack");
    idle_inputs();
    check("ack.err_sticky", 256'(err_overrun), 256'(1));

    // Abort part-way, restart together with a beat.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = 7'h7F;
      step("abort_fill");
    end
    frame_start = 1; in_valid = 1; in_data = 7'h7F;
    step("abort");
    check("abort.count0", 256'(pixel_count), 256'(0));
    for (int i = 0; i < BEATS; i++) begin
      frame_start = 0; in_valid = 1; in_data = 7'h7F;
      step("ones");
    end
    idle_inputs();
    check("ones.count196", 256'(pixel_count), 256'(196));
    check("ones.all", 256'(img_data), 256'({196{1'b1}}));
    img_ack = 1;
    step("ones_ack");
    idle_inputs();

    // Gapped input with bubbles.
    accepted = 0; cyc = 0;
    while (accepted < BEATS && cyc < 400) begin
      in_valid = ($urandom_range(0, 9) >= 3); in_data = 7'b1010101;
      if (in_valid && in_ready) accepted++;
      step("gapped");
      cyc++;
    end
    idle_inputs();
    check("gapped.beats", 256'(accepted), 256'(BEATS));
    check("gapped.img", 256'(img_data), 256'(alt_img));
    check("gapped.count", 256'(pixel_count), 256'(112));
    img_ack = 1;
    step("gapped_ack");
    idle_inputs();

    // Random data frame with bubbles.
    accepted = 0; cyc = 0;
    while (accepted < BEATS && cyc < 400) begin
      in_valid = $urandom_range(0, 3) != 0; in_data = 7'($urandom);
      if (in_valid && in_ready) accepted++;
      step("random");
      cyc++;
    end
    idle_inputs();
    check("random.beats", 256'(accepted), 256'(BEATS));
    img_ack = 1; in_valid = 1;
    step("random_ack_with_valid");
    idle_inputs();

    // Alternate geometry 8x8 with 8-bit beats.
    check("p8.ready", 256'(rdy2), 256'(1));
    for (int i = 0; i < 8; i++) begin
      v2 = 1; d2 = 8'h0F;
      @(posedge clk); #1;
      check("p8.valid_during", 256'(val2), 256'(i == 7));
    end
    v2 = 0;
    check("p8.count32", 256'(cnt2), 256'(32));
    check("p8.img", 256'(img2), 256'({8{8'h0F}}));
    check("p8.ready_full", 256'(rdy2), 256'(0));
    ack2 = 1; fs2 = 1;
    @(posedge clk); #1;
    ack2 = 0; fs2 = 0;
    check("p8.ack_fs.valid", 256'(val2), 256'(0));
    check("p8.ack_fs.ready", 256'(rdy2), 256'(1));
    check("p8.ack_fs.count", 256'(cnt2), 256'(0));
    check("p8.ack_fs.idx", 256'(idx2), 256'(0));
    check("p8.ack_fs.img", 256'(img2), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
